tx_arb: RTL and testbench
=========================

TX_ARB -- requirements
Module: tx_arb

Interface
REQ-001 SHALL have parameter: BURST, 4, max words granted to one source before re-arbitration (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: arb_en  input  1  1 = grants allowed; 0 = no new grant.
REQ-005 SHALL have ports: s0_data  input  16, s0_empty  input  1, s0_en  output  1  source 0 show-ahead pop interface (softmax result stream).
REQ-006 SHALL have ports: s1_data  input  16, s1_empty  input  1, s1_en  output  1  source 1 show-ahead pop interface (status/loopback stream).
REQ-007 SHALL have ports: tx_data  output  16, tx_empty  output  1, tx_fifo_en  input  1  sink pop interface towards uart_ctl.
REQ-008 SHALL have ports: grant  output  2  one-hot current grant (01 = s0, 10 = s1, 00 = none); cnt0, cnt1  output  16 each  words forwarded per source.

Function
REQ-009 SHALL treat sx_data as valid whenever sx_empty = 0; pulsing sx_en for one cycle pops that word, captured into holding register on the same edge.
REQ-010 SHALL contain one 16-bit holding register plus valid flag; tx_data = holding register, tx_empty = !valid.
REQ-011 SHALL consume the held word when tx_fifo_en = 1 and valid = 1; tx_fifo_en while tx_empty = 1 SHALL be ignored.
REQ-012 SHALL fill holding register when (valid = 0 or word consumed this cycle) and granted source non-empty, giving back-to-back throughput of 1 word/cycle.
REQ-013 SHALL assert at most one of s0_en/s1_en per cycle, and only for the granted source with empty = 0.
REQ-014 SHALL implement FSM IDLE, G0, G1; grant = 00/01/10 respectively.
REQ-015 IDLE: when arb_en = 1 and a source is non-empty, SHALL grant it; if both non-empty, SHALL grant the one not last served (round-robin pointer, reset value = s1 last, so s0 wins first).
REQ-016 Gx: SHALL count popped words in 4-bit burst counter, cleared on each grant entry.
REQ-017 Gx: when counter reaches BURST, SHALL switch directly to the other source if non-empty, else restart counter and keep grant if own source non-empty, else go IDLE.
REQ-018 Gx: when granted source is empty and holding register cannot be refilled, SHALL go IDLE the next cycle.
REQ-019 arb_en falling SHALL stop further pops from the next cycle, move FSM to IDLE, and leave the held word presented until consumed.
REQ-020 Pointer SHALL record the last granted source on every grant entry.
REQ-021 cnt0/cnt1 SHALL increment by 1 on each pop from s0/s1, wrapping 0xFFFF -> 0x0000.

Reset
REQ-022 rst_n low SHALL immediately force: FSM IDLE, grant = 00, valid = 0, tx_empty = 1, tx_data = 0x0000, s0_en = s1_en = 0, burst counter = 0, pointer = s1, cnt0 = cnt1 = 0.
REQ-023 Reset mid-burst SHALL discard held word with no pop issued during or on the cycle after deassertion.

Configuration
REQ-024 With TX_ARB_CNT_EN defined, cnt0/cnt1 SHALL operate per REQ-021.
REQ-025 Without TX_ARB_CNT_EN, cnt0/cnt1 SHALL be tied to 0x0000 and no counter registers instantiated; all other behaviour unchanged.

Verification
REQ-026 s0 holds 0x0011,0x0022, s1 empty, sink pops every cycle -> tx_data 0x0011 then 0x0022, grant 01, then IDLE, tx_empty = 1.
REQ-027 Both sources hold 10 words, BURST = 4, sink always ready -> order s0x4, s1x4, s0x4, s1x4, s0x2... no idle cycle at switches, s0 first.
REQ-028 s0 has 3 words, sink tx_fifo_en = 0 for 5 cycles -> exactly one s0_en pulse, tx_data stable, no data loss after sink resumes.
REQ-029 arb_en dropped mid-burst with word held -> no further sx_en, held word delivered on next tx_fifo_en, grant 00.
REQ-030 rst_n asserted during burst with valid = 1 -> outputs per REQ-022 asynchronously, first pop after release only once arb_en = 1.
REQ-031 With TX_ARB_CNT_EN, 65537 s1 words forwarded -> cnt1 = 0x0001, cnt0 = 0x0000; without macro both read 0x0000.

Source files
------------

// File: rtl/tx_arb.sv
// tx_arb: two-source round-robin arbiter feeding a single-word holding
// register towards the UART controller.
//
// Parameter
//   BURST       max words granted to one source before re-arbitration (1..15)
// Ports
//   clk, rst_n  system clock (rising edge), asynchronous active-low reset
//   arb_en      1 = grants allowed; 0 = no new grant, pops stop
//   s0_*        source 0 show-ahead pop interface (softmax result stream)
//   s1_*        source 1 show-ahead pop interface (status/loopback stream)
//   tx_*        sink pop interface: tx_data = held word, tx_empty = !valid
//   grant       one-hot current grant (01 = s0, 10 = s1, 00 = none)
//   cnt0, cnt1  words forwarded per source
//
// Build option
//   TX_ARB_CNT_EN  when defined, cnt0/cnt1 count pops (wrapping 16-bit);
//                  otherwise they are tied to zero and no counters exist.
module tx_arb #(
    parameter int unsigned BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arb_en,
    input  logic [15:0] s0_data,
    input  logic        s0_empty,
    output logic        s0_en,
    input  logic [15:0] s1_data,
    input  logic        s1_empty,
    output logic        s1_en,
    output logic [15:0] tx_data,
    output logic        tx_empty,
    input  logic        tx_fifo_en,
    output logic [1:0]  grant,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_e      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        valid_q, valid_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic        ptr_q, ptr_d;      // last served source: 0 = s0, 1 = s1

    logic consume, can_fill, pop0, pop1, pop;
    logic oth_empty, own_empty, burst_done;

    always_comb begin
        consume    = tx_fifo_en & valid_q;
        can_fill   = ~valid_q | consume;
        pop0       = (state_q == G0) & arb_en & ~s0_empty & can_fill;
        pop1       = (state_q == G1) & arb_en & ~s1_empty & can_fill;
        pop        = pop0 | pop1;
        own_empty  = (state_q == G1) ? s1_empty : s0_empty;
        oth_empty  = (state_q == G1) ? s0_empty : s1_empty;
        // The burst limit is decided on the edge of the last pop so the
        // hand-over to the other source costs no idle cycle.
        burst_done = pop & ((bcnt_q + 4'd1) == BURST_C);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        bcnt_d  = bcnt_q;
        ptr_d   = ptr_q;

        if (pop0) begin
            hold_d  = s0_data;
            valid_d = 1'b1;
        end else if (pop1) begin
            hold_d  = s1_data;
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (arb_en) begin
                    if (!s0_empty && (s1_empty || ptr_q)) begin
                        state_d = G0;
                        bcnt_d  = '0;
                        ptr_d   = 1'b0;
                    end else if (!s1_empty) begin
                        state_d = G1;
                        bcnt_d  = '0;
                        ptr_d   = 1'b1;
                    end
                end
            end
            G0, G1: begin
                if (!arb_en) begin
                    state_d = IDLE;
                end else if (burst_done) begin
                    bcnt_d = '0;
                    if (!oth_empty) begin
                        state_d = (state_q == G0) ? G1 : G0;
                        ptr_d   = (state_q == G0);
                    end
                end else if (pop) begin
                    bcnt_d = bcnt_q + 4'd1;
                end else if (own_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            valid_q <= 1'b0;
            bcnt_q  <= '0;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            bcnt_q  <= bcnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        unique case (state_q)
            G0:      grant = 2'b01;
            G1:      grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign s0_en    = pop0;
    assign s1_en    = pop1;
    assign tx_data  = hold_q;
    assign tx_empty = ~valid_q;

`ifdef TX_ARB_CNT_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (pop0) cnt0_q <= cnt0_q + 16'd1;
            if (pop1) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_tx_arb.sv
`timescale 1ns/1ps
module tb_tx_arb;
    localparam int unsigned BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n, arb_en, tx_fifo_en;
    logic [15:0] s0_data, s1_data, tx_data, cnt0, cnt1;
    logic        s0_empty, s1_empty, s0_en, s1_en, tx_empty;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    tx_arb #(.BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .s0_data(s0_data), .s0_empty(s0_empty), .s0_en(s0_en),
        .s1_data(s1_data), .s1_empty(s1_empty), .s1_en(s1_en),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_fifo_en(tx_fifo_en),
        .grant(grant), .cnt0(cnt0), .cnt1(cnt1)
    );

    int unsigned n_pass = 0, n_total = 0;
    logic [15:0] q0[$], q1[$], inflight[$], delivered[$];
    int unsigned deliv_cyc[$], popsrc[$];
    int unsigned pops0, pops1, cyc, runb, lastsrc;
    bit          live, must_switch, arb_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_src();
        s0_empty = (q0.size() == 0);
        s1_empty = (q1.size() == 0);
        s0_data  = s0_empty ? 16'h0000 : q0[0];
        s1_data  = s1_empty ? 16'h0000 : q1[0];
    endtask

    task automatic model_reset();
        inflight.delete(); delivered.delete(); deliv_cyc.delete(); popsrc.delete();
        pops0 = 0; pops1 = 0; runb = 0; lastsrc = 1;
        live = 1'b0; must_switch = 1'b0; arb_prev = 1'b0;
    endtask

    task automatic do_reset();
        arb_en = 1'b0; tx_fifo_en = 1'b0;
        q0.delete(); q1.delete(); drive_src();
        rst_n = 1'b0; model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: sample at negedge, compare against the reference model,
    // then apply the source pops/sink consumption seen at that edge.
    task automatic cycle();
        logic p0, p1, cons, own_e, oth0, oth1, arb_now;
        logic [15:0] w;
        int unsigned src;
        @(negedge clk);
        p0 = s0_en; p1 = s1_en; cons = tx_fifo_en & ~tx_empty; w = tx_data;
        arb_now = arb_en;
        chk("proto", 32'((!(p0 && p1)) && (grant != 2'b11)
                     && (!p0 || (!s0_empty && grant == 2'b01 && arb_prev))
                     && (!p1 || (!s1_empty && grant == 2'b10 && arb_prev))), 32'd1);
        chk("tx_empty", 32'(tx_empty), 32'(inflight.size() == 0));
        if (inflight.size() != 0) chk("tx_data", 32'(w), 32'(inflight[0]));
`ifdef TX_ARB_CNT_EN
        chk("cnt0", 32'(cnt0), 32'(pops0[15:0]));
        chk("cnt1", 32'(cnt1), 32'(pops1[15:0]));
`else
        chk("cnt0", 32'(cnt0), 32'h0);
        chk("cnt1", 32'(cnt1), 32'h0);
`endif
        own_e = (lastsrc == 0) ? s0_empty : s1_empty;
        oth0  = !s1_empty;
        oth1  = !s0_empty;
        @(posedge clk);
        #1;
        cyc++;
        if (cons && inflight.size() != 0) begin
            delivered.push_back(inflight.pop_front());
            deliv_cyc.push_back(cyc);
        end
        if ((p0 && q0.size() != 0) || (p1 && q1.size() != 0)) begin
            src = p0 ? 0 : 1;
            if (must_switch) chk("rr_switch", 32'(src != lastsrc), 32'd1);
            runb = (live && src == lastsrc) ? runb + 1 : 1;
            must_switch = 1'b0;
            if (runb == BURST) begin
                runb = 0;
                must_switch = p0 ? oth0 : oth1;
            end
            lastsrc = src; live = 1'b1;
            popsrc.push_back(src);
            if (p0) begin inflight.push_back(q0.pop_front()); pops0++; end
            else    begin inflight.push_back(q1.pop_front()); pops1++; end
            chk("hold_depth", 32'(inflight.size() <= 1), 32'd1);
        end else if (own_e) begin
            live = 1'b0; must_switch = 1'b0;
        end
        if (!arb_now) begin live = 1'b0; must_switch = 1'b0; end
        arb_prev = arb_now;
        drive_src();
    endtask

    task automatic run_until_deliv(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (delivered.size() < n && k < budget) begin cycle(); k++; end
        chk(tag, 32'(delivered.size()), 32'(n));
    endtask

    task automatic chk_seq(input string tag, input logic [15:0] exp_w[$]);
        for (int i = 0; i < exp_w.size(); i++)
            chk(tag, (i < delivered.size()) ? 32'(delivered[i]) : 32'hFFFF_FFFF, 32'(exp_w[i]));
    endtask

    initial begin
        logic [15:0] exp_w[$];
        int unsigned rem[2], idx[2], s, nb, k, base, sent0, sent1;

        // Reset values
        do_reset();
        rst_n = 1'b0; #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tx_empty", 32'(tx_empty), 32'h1);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_en", 32'({s0_en, s1_en}), 32'h0);
        chk("rst_cnt", 32'({cnt0, cnt1}), 32'h0);

        // Two s0 words, s1 empty, sink always ready
        do_reset();
        q0 = '{16'h0011, 16'h0022}; drive_src();
        arb_en = 1'b1; tx_fifo_en = 1'b1;
        run_until_deliv(2, 20, "two_word_done");
        exp_w = '{16'h0011, 16'h0022}; chk_seq("two_word_seq", exp_w);
        repeat (3) cycle();
        chk("two_word_idle_grant", 32'(grant), 32'h0);
        chk("two_word_idle_empty", 32'(tx_empty), 32'h1);

        // Both sources 10 words: bursts of BURST alternating, s0 first
        do_reset();
        for (int i = 0; i < 10; i++) begin
            q0.push_back(16'h0A00 + 16'(i));
            q1.push_back(16'h0B00 + 16'(i));
        end
        drive_src();
        arb_en = 1'b1; tx_fifo_en = 1'b1;
        run_until_deliv(20, 80, "rr_done");
        exp_w.delete(); rem = '{10, 10}; idx = '{0, 0}; s = 0;
        while (rem[0] + rem[1] > 0) begin
            nb = (rem[s] < BURST) ? rem[s] : BURST;
            repeat (nb) begin
                exp_w.push_back(((s == 0) ? 16'h0A00 : 16'h0B00) + 16'(idx[s]));
                idx[s]++;
            end
            rem[s] -= nb;
            if (rem[1 - s] > 0) s = 1 - s;
        end
        chk_seq("rr_order", exp_w);
        for (int i = 1; i < 18; i++)
            chk("rr_no_bubble", (i < deliv_cyc.size()) ? 32'(deliv_cyc[i] - deliv_cyc[0]) : 32'hFFFF_FFFF, 32'(i));

        // Sink stalled: a single pop, data held steady, nothing lost
        do_reset();
        q0 = '{16'h1111, 16'h2222, 16'h3333}; drive_src();
        arb_en = 1'b1; tx_fifo_en = 1'b0;
        repeat (7) cycle();
        chk("stall_one_pop", 32'(pops0), 32'd1);
        chk("stall_data", 32'(tx_data), 32'h1111);
        tx_fifo_en = 1'b1;
        run_until_deliv(3, 20, "stall_drain");
        exp_w = '{16'h1111, 16'h2222, 16'h3333}; chk_seq("stall_seq", exp_w);

        // arb_en dropped mid-burst with a word held
        do_reset();
        for (int i = 0; i < 6; i++) q0.push_back(16'h2900 + 16'(i));
        drive_src();
        arb_en = 1'b1; tx_fifo_en = 1'b1;
        k = 0;
        while (pops0 < 2 && k < 20) begin cycle(); k++; end
        chk("drop_prep", 32'(pops0), 32'd2);
        tx_fifo_en = 1'b0; arb_en = 1'b0;
        cycle();
        base = pops0 + pops1;
        repeat (4) cycle();
        chk("drop_no_pop", 32'(pops0 + pops1), 32'(base));
        chk("drop_grant", 32'(grant), 32'h0);
        chk("drop_held", 32'(tx_empty), 32'h0);
        chk("drop_data", 32'(tx_data), 32'h2901);
        tx_fifo_en = 1'b1;
        cycle();
        chk("drop_deliver", (delivered.size() == 2) ? 32'(delivered[1]) : 32'hFFFF_FFFF, 32'h2901);
        cycle();
        chk("drop_empty", 32'(tx_empty), 32'h1);
        chk("drop_no_pop2", 32'(pops0 + pops1), 32'(base));

        // Asynchronous reset during a burst with a word held
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(16'h3000 + 16'(i));
            q1.push_back(16'h3100 + 16'(i));
        end
        drive_src();
        arb_en = 1'b1; tx_fifo_en = 1'b0;
        repeat (3) cycle();
        chk("pre_rst_valid", 32'(tx_empty), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_tx_empty", 32'(tx_empty), 32'h1);
        chk("arst_tx_data", 32'(tx_data), 32'h0);
        chk("arst_en", 32'({s0_en, s1_en}), 32'h0);
        chk("arst_cnt", 32'({cnt0, cnt1}), 32'h0);
        model_reset();
        arb_en = 1'b0; tx_fifo_en = 1'b1;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("rst_no_pop", 32'(pops0 + pops1), 32'h0);
        arb_en = 1'b1;
        k = 0;
        while (pops0 + pops1 == 0 && k < 10) begin cycle(); k++; end
        chk("rst_first_src", (popsrc.size() != 0) ? 32'(popsrc[0]) : 32'hFFFF_FFFF, 32'h0);

        // Randomized traffic, then a bounded drain
        do_reset();
        sent0 = 0; sent1 = 0;
        repeat (1500) begin
            if ($urandom_range(0, 9) < 3 && q0.size() < 8) begin
                q0.push_back({1'b0, 15'(sent0)}); sent0++;
            end
            if ($urandom_range(0, 9) < 3 && q1.size() < 8) begin
                q1.push_back({1'b1, 15'(sent1)}); sent1++;
            end
            arb_en     = ($urandom_range(0, 19) != 0);
            tx_fifo_en = ($urandom_range(0, 3) != 0);
            drive_src();
            cycle();
        end
        arb_en = 1'b1; tx_fifo_en = 1'b1;
        k = 0;
        while ((q0.size() + q1.size() + inflight.size()) != 0 && k < 300) begin cycle(); k++; end
        chk("drain_done", 32'(q0.size() + q1.size() + inflight.size()), 32'h0);
        chk("drain_count", 32'(delivered.size()), 32'(sent0 + sent1));

`ifdef TX_ARB_CNT_EN
        // Counter wrap: 65537 words from s1
        do_reset();
        arb_en = 1'b1; tx_fifo_en = 1'b1;
        k = 0;
        while (pops1 < 65537 && k < 70000) begin
            if (q1.size() < 4) q1.push_back(16'(k));
            drive_src();
            cycle();
            k++;
        end
        chk("wrap_pops", 32'(pops1), 32'd65537);
        repeat (2) cycle();
        chk("wrap_cnt1", 32'(cnt1), 32'(pops1[15:0]));
        chk("wrap_cnt0", 32'(cnt0), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
